// File: rtl/uart_host_if.sv
// Command/response bundle between a job source and the uart_host serial controller.
interface uart_host_if;
  logic         job_valid;
  logic         ping_req;
  logic         cmd_ready;
  logic [255:0] midstate;
  logic [95:0]  work_data;
  logic [31:0]  nonce_min;
  logic [31:0]  nonce_max;
  logic         ack_ok;
  logic         nak;
  logic         resp_timeout;
  logic         nonce_valid;
  logic [31:0]  golden_nonce;
  logic         rx_err;

  modport master (
    output job_valid, ping_req, midstate, work_data, nonce_min, nonce_max,
    input  cmd_ready, ack_ok, nak, resp_timeout, nonce_valid, golden_nonce, rx_err
  );

  modport slave (
    input  job_valid, ping_req, midstate, work_data, nonce_min, nonce_max,
    output cmd_ready, ack_ok, nak, resp_timeout, nonce_valid, golden_nonce, rx_err
  );
endinterface

// File: rtl/uart_host.sv
// Host side of the miner serial protocol: sends PING/PUSH_JOB over its own UART TX,
// parses PONG/ACK, INVALID and MSG_NONCE replies from its own UART RX.
module uart_host #(
  parameter int CLKS_PER_BIT = 16,
  parameter int RESP_TIMEOUT = 65535
) (
  input  logic       comm_clk,
  input  logic       reset,
  input  logic       rx_serial,
  output logic       tx_serial,
  uart_host_if.slave host
);

  localparam int CW        = $clog2(CLKS_PER_BIT + 1);
  localparam int TW        = $clog2(RESP_TIMEOUT + 1);
  localparam int GAP_LIMIT = 20 * CLKS_PER_BIT;
  localparam int GW        = $clog2(GAP_LIMIT + 1);
  localparam int HALF      = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {IDLE, SEND_PING, SEND_JOB, WAIT_RESP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  tx_state_e state_q, state_d;

  logic          cmd_ready_q, cmd_ready_d;
  logic          tx_q, tx_d;
  logic [479:0]  frame_q, frame_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [CW-1:0] tx_clk_q, tx_clk_d;
  logic [5:0]    tx_left_q, tx_left_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          to_q, to_d;

  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_clk_q, rx_clk_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_vld_q, rx_vld_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_ferr_q, rx_ferr_d;

  logic          pr_active_q, pr_active_d;
  logic [2:0]    pr_cnt_q, pr_cnt_d;
  logic          pr_bad_q, pr_bad_d;
  logic [7:0]    pr_type_q, pr_type_d;
  logic [23:0]   pr_nonce_q, pr_nonce_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [31:0]   golden_q, golden_d;
  logic          ack_q, ack_d, nak_q, nak_d, nv_q, nv_d, err_q, err_d;

  logic          ack_evt, nak_evt, timeout_evt;
  logic          tx_tick, tx_last;
  logic [3:0]    data_idx;
  logic [7:0]    cur_byte;

  assign tx_tick = (tx_clk_q == CW'(CLKS_PER_BIT - 1));
  assign tx_last = tx_tick && (tx_bit_q == 4'd9) && (tx_left_q == 6'd1);

  // ---------------- TX FSM: state register ----------------
  always_ff @(posedge comm_clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---------------- TX FSM: next state ----------------
  always_comb begin
    state_d     = state_q;
    timeout_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_ready_q) begin
          if (host.job_valid)     state_d = SEND_JOB;
          else if (host.ping_req) state_d = SEND_PING;
        end
      end
      SEND_PING, SEND_JOB: begin
        if (tx_last) state_d = WAIT_RESP;
      end
      WAIT_RESP: begin
        // A reply completing on the expiry cycle takes precedence over the timeout
        if (ack_evt || nak_evt) begin
          state_d = IDLE;
        end else if (timer_q == TW'(RESP_TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- TX FSM: outputs and serializer ----------------
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    to_d        = timeout_evt;
    timer_d     = (state_q == WAIT_RESP) ? timer_q + 1'b1 : '0;
    frame_d     = frame_q;
    tx_bit_d    = tx_bit_q;
    tx_clk_d    = tx_clk_q;
    tx_left_d   = tx_left_q;
    tx_d        = 1'b1;
    data_idx    = '0;
    cur_byte    = '0;

    if (state_q == IDLE && state_d == SEND_JOB) begin
      // Byte 0 sits in the low byte; each completed byte shifts the frame down
      frame_d   = {host.midstate, host.work_data, host.nonce_min, host.nonce_max,
                   32'h0000_0000, 8'h02, 8'h00, 8'h00, 8'd60};
      tx_left_d = 6'd60;
      tx_bit_d  = '0;
      tx_clk_d  = '0;
    end else if (state_q == IDLE && state_d == SEND_PING) begin
      frame_d   = '0;
      tx_left_d = 6'd1;
      tx_bit_d  = '0;
      tx_clk_d  = '0;
    end else if (state_q == SEND_PING || state_q == SEND_JOB) begin
      if (tx_tick) begin
        tx_clk_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_bit_d  = '0;
          tx_left_d = tx_left_q - 1'b1;
          frame_d   = frame_q >> 8;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
        end
      end else begin
        tx_clk_d = tx_clk_q + 1'b1;
      end
    end

    if (state_d == SEND_PING || state_d == SEND_JOB) begin
      cur_byte = frame_d[7:0];
      data_idx = tx_bit_d - 4'd1;
      case (tx_bit_d)
        4'd0:    tx_d = 1'b0;
        4'd9:    tx_d = 1'b1;
        default: tx_d = cur_byte[data_idx[2:0]];
      endcase
    end
  end

  // ---------------- UART RX ----------------
  always_comb begin
    rx_s1_d    = rx_serial;
    rx_s2_d    = rx_s1_q;
    rx_s3_d    = rx_s2_q;
    rx_state_d = rx_state_q;
    rx_clk_d   = rx_clk_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_vld_d   = 1'b0;
    rx_ferr_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          rx_clk_d   = '0;
        end
      end
      RX_START: begin
        if (rx_clk_q == CW'(HALF - 1)) begin
          rx_clk_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_clk_d = rx_clk_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_clk_q == CW'(CLKS_PER_BIT - 1)) begin
          rx_clk_d   = '0;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_clk_d = rx_clk_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_clk_q == CW'(CLKS_PER_BIT - 1)) begin
          rx_clk_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_s2_q) begin
            rx_vld_d  = 1'b1;
            rx_byte_d = rx_shift_q;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end else begin
          rx_clk_d = rx_clk_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- Reply parser ----------------
  always_comb begin
    pr_active_d = pr_active_q;
    pr_cnt_d    = pr_cnt_q;
    pr_bad_d    = pr_bad_q;
    pr_type_d   = pr_type_q;
    pr_nonce_d  = pr_nonce_q;
    gap_d       = gap_q;
    golden_d    = golden_q;
    ack_evt     = 1'b0;
    nak_evt     = 1'b0;
    nv_d        = 1'b0;
    err_d       = rx_ferr_q;
    if (rx_vld_q) begin
      gap_d = '0;
      if (!pr_active_q) begin
        if (rx_byte_q == 8'h01) begin
          ack_evt = (state_q == WAIT_RESP);
        end else if (rx_byte_q == 8'h08) begin
          pr_active_d = 1'b1;
          pr_cnt_d    = 3'd1;
          pr_bad_d    = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        pr_cnt_d = pr_cnt_q + 1'b1;
        case (pr_cnt_q)
          3'd1, 3'd2: if (rx_byte_q != 8'h00) pr_bad_d = 1'b1;
          3'd3:       pr_type_d  = rx_byte_q;
          3'd4, 3'd5, 3'd6: pr_nonce_d = {pr_nonce_q[15:0], rx_byte_q};
          default: begin
            pr_active_d = 1'b0;
            if (pr_bad_q) begin
              err_d = 1'b1;
            end else if (pr_type_q == 8'h03) begin
              golden_d = {pr_nonce_q, rx_byte_q};
              nv_d     = 1'b1;
            end else if (pr_type_q == 8'h01) begin
              nak_evt = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        endcase
      end
    end else if (pr_active_q) begin
      // Gap is measured only while the line is idle between bytes
      if (rx_state_q != RX_IDLE) begin
        gap_d = '0;
      end else if (gap_q == GW'(GAP_LIMIT)) begin
        pr_active_d = 1'b0;
        gap_d       = '0;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
    ack_d = ack_evt;
    nak_d = nak_evt;
  end

  // ---------------- Datapath registers ----------------
  always_ff @(posedge comm_clk) begin
    if (reset) begin
      cmd_ready_q <= 1'b0;
      tx_q        <= 1'b1;
      frame_q     <= '0;
      tx_bit_q    <= '0;
      tx_clk_q    <= '0;
      tx_left_q   <= '0;
      timer_q     <= '0;
      to_q        <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_clk_q    <= '0;
      rx_bit_q    <= '0;
      rx_shift_q  <= '0;
      rx_vld_q    <= 1'b0;
      rx_byte_q   <= '0;
      rx_ferr_q   <= 1'b0;
      pr_active_q <= 1'b0;
      pr_cnt_q    <= '0;
      pr_bad_q    <= 1'b0;
      pr_type_q   <= '0;
      pr_nonce_q  <= '0;
      gap_q       <= '0;
      golden_q    <= '0;
      ack_q       <= 1'b0;
      nak_q       <= 1'b0;
      nv_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cmd_ready_q <= cmd_ready_d;
      tx_q        <= tx_d;
      frame_q     <= frame_d;
      tx_bit_q    <= tx_bit_d;
      tx_clk_q    <= tx_clk_d;
      tx_left_q   <= tx_left_d;
      timer_q     <= timer_d;
      to_q        <= to_d;
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_s3_q     <= rx_s3_d;
      rx_state_q  <= rx_state_d;
      rx_clk_q    <= rx_clk_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      rx_vld_q    <= rx_vld_d;
      rx_byte_q   <= rx_byte_d;
      rx_ferr_q   <= rx_ferr_d;
      pr_active_q <= pr_active_d;
      pr_cnt_q    <= pr_cnt_d;
      pr_bad_q    <= pr_bad_d;
      pr_type_q   <= pr_type_d;
      pr_nonce_q  <= pr_nonce_d;
      gap_q       <= gap_d;
      golden_q    <= golden_d;
      ack_q       <= ack_d;
      nak_q       <= nak_d;
      nv_q        <= nv_d;
      err_q       <= err_d;
    end
  end

  assign tx_serial         = tx_q;
  assign host.cmd_ready    = cmd_ready_q;
  assign host.ack_ok       = ack_q;
  assign host.nak          = nak_q;
  assign host.resp_timeout = to_q;
  assign host.nonce_valid  = nv_q;
  assign host.golden_nonce = golden_q;
  assign host.rx_err       = err_q;

endmodule

// File: tb/tb_uart_host.sv
// Directed bench for uart_host: command serialization, reply parsing, timeouts, RX faults, reset.
module tb_uart_host;
  localparam int CPB = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic rx  = 1'b1;
  logic rx2 = 1'b1;
  logic tx, tx2;

  uart_host_if hif();
  uart_host_if hif2();

  uart_host #(.CLKS_PER_BIT(CPB), .RESP_TIMEOUT(2000)) dut (
    .comm_clk(clk), .reset(reset), .rx_serial(rx), .tx_serial(tx), .host(hif)
  );

  uart_host #(.CLKS_PER_BIT(CPB), .RESP_TIMEOUT(100)) dut2 (
    .comm_clk(clk), .reset(reset), .rx_serial(rx2), .tx_serial(tx2), .host(hif2)
  );

  int n_vec = 0;
  int n_bad = 0;
  int ack_c = 0, nak_c = 0, nv_c = 0, err_c = 0, to_c = 0;

  always @(posedge clk) begin
    if (hif.ack_ok === 1'b1)       ack_c++;
    if (hif.nak === 1'b1)          nak_c++;
    if (hif.nonce_valid === 1'b1)  nv_c++;
    if (hif.rx_err === 1'b1)       err_c++;
    if (hif.resp_timeout === 1'b1) to_c++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic rx_frame(input logic [63:0] f);
    for (int i = 7; i >= 0; i--) rx_byte(f[i*8 +: 8], 1'b1);
  endtask

  task automatic tx_get(output logic [7:0] b, output int wait_c, output logic ok);
    ok = 1'b1;
    wait_c = 0;
    b = '0;
    while (tx !== 1'b0 && wait_c < 2000) begin
      @(negedge clk);
      wait_c++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    tick(CPB / 2);
    for (int i = 0; i < 8; i++) begin
      tick(CPB);
      b[i] = tx;
    end
    tick(CPB);
    if (tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic test_reset();
    hif.job_valid = 0; hif.ping_req = 0; hif.midstate = '0; hif.work_data = '0;
    hif.nonce_min = '0; hif.nonce_max = '0;
    hif2.job_valid = 0; hif2.ping_req = 0; hif2.midstate = '0; hif2.work_data = '0;
    hif2.nonce_min = '0; hif2.nonce_max = '0;
    reset = 1'b1;
    tick(3);
    if (tx !== 1'b1) begin $display("FAIL reset_tx: got %b want 1", tx); n_bad++; end
    n_vec++;
    if (hif.cmd_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", hif.cmd_ready); n_bad++; end
    n_vec++;
    if ({hif.ack_ok, hif.nak, hif.resp_timeout, hif.nonce_valid, hif.rx_err} !== 5'b0) begin
      $display("FAIL reset_pulses: got %b want 00000",
               {hif.ack_ok, hif.nak, hif.resp_timeout, hif.nonce_valid, hif.rx_err});
      n_bad++;
    end
    n_vec++;
    if (hif.golden_nonce !== 32'h0) begin $display("FAIL reset_golden: got %h want 0", hif.golden_nonce); n_bad++; end
    n_vec++;
    reset = 1'b0;
    tick(1);
    if (hif.cmd_ready !== 1'b1) begin $display("FAIL reset_release_ready: got %b want 1", hif.cmd_ready); n_bad++; end
    n_vec++;
    if (hif2.cmd_ready !== 1'b1) begin $display("FAIL reset_release_ready2: got %b want 1", hif2.cmd_ready); n_bad++; end
    n_vec++;
  endtask

  task automatic test_ping();
    logic [7:0] b; int w; logic ok; int a0, e0;
    a0 = ack_c; e0 = err_c;
    hif.ping_req = 1'b1;
    tick(1);
    if (hif.cmd_ready !== 1'b0) begin $display("FAIL ping_ready_drop: got %b want 0", hif.cmd_ready); n_bad++; end
    n_vec++;
    if (tx !== 1'b0) begin $display("FAIL ping_start_bit: got %b want 0", tx); n_bad++; end
    n_vec++;
    hif.ping_req = 1'b0;
    tx_get(b, w, ok);
    if (ok !== 1'b1 || b !== 8'h00) begin $display("FAIL ping_byte: got %h ok=%b want 00 ok=1", b, ok); n_bad++; end
    n_vec++;
    rx_byte(8'h01, 1'b1);
    tick(CPB);
    if (ack_c - a0 !== 1) begin $display("FAIL ping_ack: got %0d pulses want 1", ack_c - a0); n_bad++; end
    n_vec++;
    if (hif.cmd_ready !== 1'b1) begin $display("FAIL ping_ready_back: got %b want 1", hif.cmd_ready); n_bad++; end
    n_vec++;
    if (err_c - e0 !== 0) begin $display("FAIL ping_no_err: got %0d want 0", err_c - e0); n_bad++; end
    n_vec++;
  endtask

  task automatic test_nonce_idle();
    int v0, e0;
    v0 = nv_c; e0 = err_c;
    rx_frame(64'h08000003_38b9b05a);
    tick(CPB);
    if (nv_c - v0 !== 1) begin $display("FAIL nonce_idle_pulse: got %0d want 1", nv_c - v0); n_bad++; end
    n_vec++;
    if (hif.golden_nonce !== 32'h38b9b05a) begin $display("FAIL nonce_idle_value: got %h want 38b9b05a", hif.golden_nonce); n_bad++; end
    n_vec++;
    if (err_c - e0 !== 0) begin $display("FAIL nonce_idle_err: got %0d want 0", err_c - e0); n_bad++; end
    n_vec++;
  endtask

  task automatic test_job_with_nonce();
    logic [7:0] b; int w; logic ok; int v0, a0; int bad_gaps;
    logic [7:0] exp;
    v0 = nv_c; a0 = ack_c; bad_gaps = 0;
    hif.nonce_min = 32'h1FFFFFFF;
    hif.nonce_max = 32'h0;
    hif.work_data = 96'h131211100f0e0d0c0b0a0908;
    hif.midstate  = 256'h33323130_2f2e2d2c_2b2a2928_27262524_23222120_1f1e1d1c_1b1a1918_17161514;
    hif.job_valid = 1'b1;
    hif.ping_req  = 1'b1;
    tick(1);
    if (hif.cmd_ready !== 1'b0) begin $display("FAIL job_ready_drop: got %b want 0", hif.cmd_ready); n_bad++; end
    n_vec++;
    hif.job_valid = 1'b0;
    hif.ping_req  = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          tx_get(b, w, ok);
          if (i == 0)       exp = 8'd60;
          else if (i == 3)  exp = 8'h02;
          else if (i < 12)  exp = 8'h00;
          else if (i < 15)  exp = 8'hFF;
          else if (i == 15) exp = 8'h1F;
          else              exp = 8'(i - 8);
          if (ok !== 1'b1 || b !== exp) begin
            $display("FAIL job_byte[%0d]: got %h ok=%b want %h", i, b, ok, exp); n_bad++;
          end
          n_vec++;
          if (i > 0 && w != CPB / 2) bad_gaps++;
        end
      end
      begin
        tick(50 * CPB);
        rx_frame(64'h08000003_a5c30f71);
      end
    join
    if (bad_gaps !== 0) begin $display("FAIL job_back_to_back: got %0d gapped bytes want 0", bad_gaps); n_bad++; end
    n_vec++;
    if (nv_c - v0 !== 1) begin $display("FAIL job_nonce_pulse: got %0d want 1", nv_c - v0); n_bad++; end
    n_vec++;
    if (hif.golden_nonce !== 32'ha5c30f71) begin $display("FAIL job_nonce_value: got %h want a5c30f71", hif.golden_nonce); n_bad++; end
    n_vec++;
    rx_byte(8'h01, 1'b1);
    tick(CPB);
    if (ack_c - a0 !== 1) begin $display("FAIL job_ack: got %0d want 1", ack_c - a0); n_bad++; end
    n_vec++;
    if (hif.cmd_ready !== 1'b1) begin $display("FAIL job_ready_back: got %b want 1", hif.cmd_ready); n_bad++; end
    n_vec++;
  endtask

  task automatic test_nak();
    logic [7:0] b; int w; logic ok; int n0, t0, a0;
    n0 = nak_c; t0 = to_c; a0 = ack_c;
    hif.ping_req = 1'b1;
    tick(1);
    hif.ping_req = 1'b0;
    tx_get(b, w, ok);
    if (ok !== 1'b1 || b !== 8'h00) begin $display("FAIL nak_ping_byte: got %h want 00", b); n_bad++; end
    n_vec++;
    rx_frame(64'h08000001_00000000);
    tick(CPB);
    if (nak_c - n0 !== 1) begin $display("FAIL nak_pulse: got %0d want 1", nak_c - n0); n_bad++; end
    n_vec++;
    if (hif.cmd_ready !== 1'b1) begin $display("FAIL nak_idle: got %b want 1", hif.cmd_ready); n_bad++; end
    n_vec++;
    tick(2100);
    if (to_c - t0 !== 0) begin $display("FAIL nak_no_timeout: got %0d want 0", to_c - t0); n_bad++; end
    n_vec++;
    if (ack_c - a0 !== 0) begin $display("FAIL nak_no_ack: got %0d want 0", ack_c - a0); n_bad++; end
    n_vec++;
  endtask

  task automatic test_timeout();
    int n;
    hif2.ping_req = 1'b1;
    tick(1);
    hif2.ping_req = 1'b0;
    if (tx2 !== 1'b0) begin $display("FAIL to_start_bit: got %b want 0", tx2); n_bad++; end
    n_vec++;
    n = 0;
    while (hif2.resp_timeout !== 1'b1 && n < 1000) begin
      tick(1);
      n++;
    end
    if (n !== 10 * CPB + 100) begin $display("FAIL to_latency: got %0d cycles want %0d", n, 10 * CPB + 100); n_bad++; end
    n_vec++;
    tick(1);
    if (hif2.resp_timeout !== 1'b0) begin $display("FAIL to_one_cycle: got %b want 0", hif2.resp_timeout); n_bad++; end
    n_vec++;
    if (hif2.cmd_ready !== 1'b1) begin $display("FAIL to_idle: got %b want 1", hif2.cmd_ready); n_bad++; end
    n_vec++;
  endtask

  task automatic test_rx_faults();
    int e0, a0, v0;
    e0 = err_c; a0 = ack_c;
    rx_byte(8'h01, 1'b0);
    tick(CPB);
    if (err_c - e0 !== 1 || ack_c - a0 !== 0) begin
      $display("FAIL fault_stop: got err=%0d ack=%0d want err=1 ack=0", err_c - e0, ack_c - a0); n_bad++;
    end
    n_vec++;
    e0 = err_c;
    rx_byte(8'h06, 1'b1);
    tick(CPB);
    if (err_c - e0 !== 1) begin $display("FAIL fault_lead: got %0d want 1", err_c - e0); n_bad++; end
    n_vec++;
    e0 = err_c; v0 = nv_c;
    rx_frame(64'h08000007_00000000);
    tick(CPB);
    if (err_c - e0 !== 1 || nv_c - v0 !== 0) begin
      $display("FAIL fault_type: got err=%0d nv=%0d want err=1 nv=0", err_c - e0, nv_c - v0); n_bad++;
    end
    n_vec++;
    e0 = err_c;
    rx_frame(64'h08010003_11223344);
    tick(CPB);
    if (err_c - e0 !== 1 || hif.golden_nonce !== 32'ha5c30f71) begin
      $display("FAIL fault_header: got err=%0d golden=%h want err=1 golden=a5c30f71", err_c - e0, hif.golden_nonce); n_bad++;
    end
    n_vec++;
    e0 = err_c; a0 = ack_c;
    rx_byte(8'h01, 1'b1);
    tick(CPB);
    if (err_c - e0 !== 0 || ack_c - a0 !== 0) begin
      $display("FAIL pong_idle_drop: got err=%0d ack=%0d want 0 0", err_c - e0, ack_c - a0); n_bad++;
    end
    n_vec++;
    e0 = err_c;
    rx = 1'b0;
    tick(2);
    rx = 1'b1;
    tick(3 * CPB);
    if (err_c - e0 !== 0) begin $display("FAIL glitch_ignored: got %0d want 0", err_c - e0); n_bad++; end
    n_vec++;
    e0 = err_c; v0 = nv_c;
    rx_byte(8'h08, 1'b1);
    rx_byte(8'h00, 1'b1);
    tick(25 * CPB);
    rx_frame(64'h08000003_0badf00d);
    tick(CPB);
    if (err_c - e0 !== 0 || nv_c - v0 !== 1 || hif.golden_nonce !== 32'h0badf00d) begin
      $display("FAIL gap_discard: got err=%0d nv=%0d golden=%h want 0 1 0badf00d",
               err_c - e0, nv_c - v0, hif.golden_nonce); n_bad++;
    end
    n_vec++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] b; int w; logic ok; int n, a0;
    hif.job_valid = 1'b1;
    tick(1);
    hif.job_valid = 1'b0;
    tick(100 * CPB);
    n = 0;
    while (tx !== 1'b0 && n < 200) begin tick(1); n++; end
    if (tx !== 1'b0) begin $display("FAIL mid_find_low: got %b want 0", tx); n_bad++; end
    n_vec++;
    reset = 1'b1;
    tick(1);
    if (tx !== 1'b1 || hif.cmd_ready !== 1'b0) begin
      $display("FAIL mid_reset_tx: got tx=%b ready=%b want 1 0", tx, hif.cmd_ready); n_bad++;
    end
    n_vec++;
    if (hif.golden_nonce !== 32'h0) begin $display("FAIL mid_reset_golden: got %h want 0", hif.golden_nonce); n_bad++; end
    n_vec++;
    tick(2);
    reset = 1'b0;
    tick(1);
    if (hif.cmd_ready !== 1'b1) begin $display("FAIL mid_release_ready: got %b want 1", hif.cmd_ready); n_bad++; end
    n_vec++;
    a0 = ack_c;
    hif.ping_req = 1'b1;
    tick(1);
    hif.ping_req = 1'b0;
    tx_get(b, w, ok);
    if (ok !== 1'b1 || b !== 8'h00) begin $display("FAIL mid_ping_byte: got %h ok=%b want 00 ok=1", b, ok); n_bad++; end
    n_vec++;
    rx_byte(8'h01, 1'b1);
    tick(CPB);
    if (ack_c - a0 !== 1 || hif.cmd_ready !== 1'b1) begin
      $display("FAIL mid_ping_ack: got ack=%0d ready=%b want 1 1", ack_c - a0, hif.cmd_ready); n_bad++;
    end
    n_vec++;
  endtask

  initial begin
    test_reset();
    test_ping();
    test_nonce_idle();
    test_job_with_nonce();
    test_nak();
    test_timeout();
    test_rx_faults();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
